// File: rtl/weight_preload_shifter_pkg.sv
// ----------------------------------------------------------------------------
// weight_preload_shifter_pkg
//   Shared constants and types for the weight preload shifter.
//   - DATA_SIZE / ARRAY_SIZE : weight width and PE array dimension
//   - ROW_W / TILE_W         : widths of one weight row and of a full tile
//   - CNT_W                  : row counter width ($clog2(ARRAY_SIZE), min 1)
//   - state_e                : shifter FSM encoding (2'd3 is illegal)
//   - next_row_index()       : row emitted in the cycle after row_cnt
// ----------------------------------------------------------------------------
package weight_preload_shifter_pkg;

  localparam int DATA_SIZE  = 16;
  localparam int ARRAY_SIZE = 9;
  localparam int ROW_W      = ARRAY_SIZE * DATA_SIZE;
  localparam int TILE_W     = ARRAY_SIZE * ROW_W;
  localparam int CNT_W      = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Rows leave top-down, so while row_cnt is being shown the next row to
  // register is ARRAY_SIZE-2-row_cnt. Clamped at 0 so the part-select never
  // leaves the tile on the last row, where the value is not used anyway.
  function automatic logic [CNT_W-1:0] next_row_index(input logic [CNT_W-1:0] row_cnt);
    if (row_cnt >= CNT_W'(ARRAY_SIZE - 2)) begin
      return '0;
    end
    return CNT_W'(ARRAY_SIZE - 2) - row_cnt;
  endfunction

endpackage

// File: rtl/weight_preload_shifter.sv
// ----------------------------------------------------------------------------
// weight_preload_shifter
//   Takes complete weight tiles from weight_fill_control and loads them into
//   the systolic PE array one row per cycle, top row first. One staging
//   register lets the next tile be accepted while the current one shifts. A
//   new shift starts only from IDLE while the array is not busy.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high; clears all state
//   tile_in        in   TILE_W   row r at [r*ROW_W +: ROW_W], column c at
//                                [c*DATA_SIZE +: DATA_SIZE] within the row
//   tile_valid     in   tile_in valid (held by upstream until accepted)
//   tile_ready     out  staging register empty
//   array_busy     in   PE array busy; blocks starting a new shift
//   shift_out      out  ROW_W    weight row into the array (0 when idle)
//   shift_en       out  shift_out valid, high ARRAY_SIZE cycles per tile
//   weights_loaded out  one-cycle pulse after the last row has shifted
// ----------------------------------------------------------------------------
module weight_preload_shifter
  import weight_preload_shifter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [TILE_W-1:0] tile_in,
  input  logic              tile_valid,
  output logic              tile_ready,
  input  logic              array_busy,
  output logic [ROW_W-1:0]  shift_out,
  output logic              shift_en,
  output logic              weights_loaded
);

  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ARRAY_SIZE - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   row_cnt_q;
  logic [TILE_W-1:0]  stage_q;
  logic [TILE_W-1:0]  work_q;
  logic               staged_full_q;
  logic [ROW_W-1:0]   shift_out_q;
  logic               shift_en_q;
  logic               loaded_q;

  logic               accept;
  logic [CNT_W-1:0]   next_idx_d;
  logic [ROW_W-1:0]   next_row_d;
  logic [ROW_W-1:0]   first_row_d;

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    accept      = tile_valid && !staged_full_q;
    next_idx_d  = next_row_index(row_cnt_q);
    next_row_d  = work_q[int'(next_idx_d) * ROW_W +: ROW_W];
    // The first row is taken straight from staging because work_q is only
    // being loaded on the IDLE->SHIFT edge.
    first_row_d = stage_q[(ARRAY_SIZE - 1) * ROW_W +: ROW_W];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the tile registers are reset too; a reset must leave no stale
      // tile behind, and the staged tile is defined as lost.
      state_q       <= IDLE;
      row_cnt_q     <= '0;
      stage_q       <= '0;
      work_q        <= '0;
      staged_full_q <= 1'b0;
      shift_out_q   <= '0;
      shift_en_q    <= 1'b0;
      loaded_q      <= 1'b0;
    end else begin
      // Output defaults: outputs are idle unless a SHIFT row is produced.
      shift_en_q  <= 1'b0;
      shift_out_q <= '0;
      loaded_q    <= 1'b0;

      // Accept requires an empty stage, so it can never coincide with the
      // IDLE->SHIFT hand-off below that empties it.
      if (accept) begin
        stage_q       <= tile_in;
        staged_full_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (staged_full_q && !array_busy) begin
            work_q        <= stage_q;
            staged_full_q <= 1'b0;
            row_cnt_q     <= '0;
            state_q       <= SHIFT;
            shift_en_q    <= 1'b1;
            shift_out_q   <= first_row_d;
          end
        end

        SHIFT: begin
          // array_busy is deliberately ignored here: a started tile always
          // completes.
          if (row_cnt_q == LAST_ROW) begin
            state_q  <= DONE;
            loaded_q <= 1'b1;
          end else begin
            row_cnt_q   <= row_cnt_q + CNT_W'(1);
            shift_en_q  <= 1'b1;
            shift_out_q <= next_row_d;
          end
        end

        DONE: begin
          // Always pass through IDLE, giving one idle cycle between tiles.
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tile_ready     = !staged_full_q;
  assign shift_out      = shift_out_q;
  assign shift_en       = shift_en_q;
  assign weights_loaded = loaded_q;

endmodule
